// File: rtl/wrpg_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wrpg_pkg : shared types and defaults for the weighted random pattern generator
// Revision 1.0
// ---------------------------------------------------------------------------
package wrpg_pkg;

    typedef enum logic [1:0] {
        PR_LOAD   = 2'd0,
        PR_SHIFT  = 2'd1,
        PR_ROTATE = 2'd2,
        PR_LFSR   = 2'd3
    } pr_mode_e;

    // Defaults for the 8-bit configuration; taps 7,5,4,3 give a maximal sequence.
    localparam logic [7:0] PR_SEED8 = 8'h01;
    localparam logic [7:0] PR_TAPS8 = 8'hB8;

endpackage : wrpg_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sat_counter : W-bit up counter with synchronous clear, saturates at all-ones
// Revision 1.0
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule : sat_counter
`default_nettype wire

// File: rtl/pattern_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pattern_reg : pattern word with load/shift/rotate/LFSR update and step count
// Revision 1.0
// ---------------------------------------------------------------------------
module pattern_reg
    import wrpg_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(PR_SEED8),
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(PR_TAPS8),
    parameter int               CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             en,
    input  pr_mode_e         mode,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] q_next;
    logic             feedback;

    assign feedback = ^(q & TAPS);

    always_comb begin
        q_next = q;
        case (mode)
            PR_LOAD:   q_next = d;
            PR_SHIFT:  q_next = {q[WIDTH-2:0], si};
            PR_ROTATE: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            PR_LFSR:   q_next = (q == '0) ? SEED : {q[WIDTH-2:0], feedback};
            default:   q_next = q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (set) begin
            q <= SEED;
        end else if (en) begin
            q <= q_next;
        end
    end

    // set clears the count even when en is also high.
    sat_counter #(
        .W (CNT_W)
    ) u_step_cnt (
        .clk (clk),
        .rst (rst),
        .clr (set),
        .inc (en),
        .cnt (count)
    );

    assign so   = q[WIDTH-1];
    assign zero = (q == '0);

endmodule : pattern_reg
`default_nettype wire

// File: tb/tb_pattern_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pattern_reg : directed + random checks of pattern_reg against a reference model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pattern_reg;
    import wrpg_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       set = 1'b0;
    logic       en  = 1'b0;
    pr_mode_e   mode = PR_LOAD;
    logic [7:0] d   = 8'h00;
    logic       si  = 1'b0;

    logic [7:0]  q, q3;
    logic        so, so3, zero, zero3;
    logic [15:0] count;
    logic [2:0]  count3;

    int checks = 0;
    int errors = 0;

    // reference state
    int mq  = 0;
    int mc  = 0;
    int mc3 = 0;

    always #5 clk = ~clk;

    pattern_reg #(.WIDTH(8), .SEED(8'h01), .TAPS(8'hB8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .set(set), .en(en), .mode(mode), .d(d), .si(si),
        .q(q), .so(so), .count(count), .zero(zero)
    );

    pattern_reg #(.WIDTH(8), .SEED(8'h01), .TAPS(8'hB8), .CNT_W(3)) dut3 (
        .clk(clk), .rst(rst), .set(set), .en(en), .mode(mode), .d(d), .si(si),
        .q(q3), .so(so3), .count(count3), .zero(zero3)
    );

    function automatic int parity(input int v);
        int c = 0;
        for (int i = 0; i < 8; i++) c += (v >> i) & 1;
        return c % 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("q", 32'(q), 32'(mq));
        check("so", 32'(so), 32'((mq >> 7) & 1));
        check("zero", 32'(zero), 32'(mq == 0));
        check("count", 32'(count), 32'(mc));
        check("count3", 32'(count3), 32'(mc3));
    endtask

    task automatic model_edge();
        if (set) begin
            mq = 1; mc = 0; mc3 = 0;
        end else if (en) begin
            case (mode)
                PR_LOAD:   mq = int'(d);
                PR_SHIFT:  mq = ((mq << 1) | int'(si)) & 255;
                PR_ROTATE: mq = ((mq << 1) | (mq >> 7)) & 255;
                default:   mq = (mq == 0) ? 1 : (((mq << 1) | parity(mq & 'hB8)) & 255);
            endcase
            if (mc < 65535) mc = mc + 1;
            if (mc3 < 7) mc3 = mc3 + 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        mq = 0; mc = 0; mc3 = 0;
        #1;
        check_model();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] lfsr_exp [4];
        lfsr_exp[0] = 8'h02; lfsr_exp[1] = 8'h04; lfsr_exp[2] = 8'h08; lfsr_exp[3] = 8'h11;

        // reset state
        #2;
        check("rst_q", 32'(q), 32'h0);
        check("rst_zero", 32'(zero), 32'h1);
        check("rst_so", 32'(so), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // lock-up recovery from q = 0
        mode = PR_LFSR; en = 1'b1;
        step();
        check("lockup_q", 32'(q), 32'h01);
        check("lockup_cnt", 32'(count), 32'd1);

        // same situation with set asserted: set wins, count stays 0
        en = 1'b0;
        apply_reset();
        set = 1'b1; en = 1'b1; mode = PR_LFSR;
        step();
        check("set_en_q", 32'(q), 32'h01);
        check("set_en_cnt", 32'(count), 32'd0);

        // LFSR sequence from seed
        set = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("lfsr_seq", 32'(q), 32'(lfsr_exp[i]));
        end
        check("lfsr_cnt", 32'(count), 32'd4);

        // load then shift
        mode = PR_LOAD; d = 8'hA5;
        step();
        check("load_so", 32'(so), 32'h1);
        mode = PR_SHIFT; si = 1'b1;
        step();
        check("shift1_q", 32'(q), 32'h4B);
        si = 1'b0;
        step();
        check("shift0_q", 32'(q), 32'h96);
        check("shift0_so", 32'(so), 32'h1);

        // rotate
        mode = PR_LOAD; d = 8'h81;
        step();
        mode = PR_ROTATE;
        step();
        check("rot1_q", 32'(q), 32'h03);
        step();
        check("rot2_q", 32'(q), 32'h06);

        // saturation of the 3-bit counter, then hold
        set = 1'b1;
        step();
        set = 1'b0; en = 1'b1; mode = PR_LFSR;
        for (int i = 1; i <= 9; i++) begin
            step();
            check("sat_cnt3", 32'(count3), 32'((i < 7) ? i : 7));
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode = pr_mode_e'($urandom_range(0, 3));
            d = 8'($urandom);
            step();
        end

        // async reset between edges while LFSR runs
        en = 1'b1; mode = PR_LFSR;
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        mq = 0; mc = 0; mc3 = 0;
        check("async_q", 32'(q), 32'h0);
        check("async_cnt", 32'(count), 32'h0);
        check("async_zero", 32'(zero), 32'h1);
        @(negedge clk);
        rst = 1'b1;

        // random operation
        for (int i = 0; i < 300; i++) begin
            set  = ($urandom_range(0, 19) == 0);
            en   = ($urandom_range(0, 3) != 0);
            mode = pr_mode_e'($urandom_range(0, 3));
            d    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            si   = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pattern_reg
`default_nettype wire

// File: doc/pattern_reg.md
# pattern_reg

Parametrised pattern register for the weighted random pattern generator datapath; the generalised successor of the 8-bit set/reset/enable flip-flop bank. Holds a WIDTH-bit pattern word and, when enabled, loads it in parallel, shifts in a serial bit, rotates it, or advances it one LFSR step with programmable taps. A saturating step counter tracks enabled updates since the last reset or set. It feeds the weighting logic and acts as the seed/shift stage of the generator.

## Interface
- WIDTH, 8: pattern width in bits (≥2).
- SEED, 'h01 (WIDTH bits): value loaded by `set` and by LFSR lock-up recovery.
- TAPS, 'hB8 (WIDTH bits): LFSR feedback mask. Bit i set means q[i] contributes to the feedback.
- CNT_W, 16: step counter width.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- set  in  1  synchronous preload of SEED.
- en  in  1  update enable.
- mode  in  2  update mode: 0 LOAD, 1 SHIFT, 2 ROTATE, 3 LFSR.
- d  in  WIDTH  parallel load data.
- si  in  1  serial input for SHIFT.
- q  out  WIDTH  registered pattern.
- so  out  1  serial out, equal to q[WIDTH-1].
- count  out  CNT_W  registered step count.
- zero  out  1  combinational flag, q == 0.

## Operation
- Priority is rst (async) > set > en > hold.
- rst low, at any time: q = 0, count = 0, so = 0, zero = 1. The block stays there until rst is high at a clock edge.
- set = 1: q <= SEED and count <= 0, regardless of en and mode.
- en = 0 with set = 0: q and count hold.
- en = 1 with set = 0, next q by mode:
  - LOAD: q <= d.
  - SHIFT: q <= {q[WIDTH-2:0], si}.
  - ROTATE: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - LFSR: q <= {q[WIDTH-2:0], ^(q & TAPS)}.
  - LFSR lock-up: if q == 0, q <= SEED instead.
- count increments by 1 on every en = 1, set = 0 edge, in all modes. It saturates at 2^CNT_W−1 and never wraps.
- so is q[WIDTH-1] of the current q. It is therefore the bit being shifted out by the next SHIFT.

## Timing
- Single clock domain. All state updates on the rising clk edge.
- Latency is 1 cycle: inputs sampled at edge k appear on q and count after edge k.
- so and zero derive combinationally from registered q. No extra latency.
- Reset assertion is asynchronous and immediate. Deassertion is synchronised externally, and the first update is at the first edge with rst high.
- set and en asserted together: set wins, and count = 0 (not 1).
- Mode changes take effect on the next enabled edge. No mode-internal state exists.
- Counter at saturation with en = 1: count unchanged; q still updates.

## Structure
- Shared package `wrpg_pkg`:
  - typedef `pr_mode_e` (2-bit enum: PR_LOAD, PR_SHIFT, PR_ROTATE, PR_LFSR).
  - default SEED and TAPS constants for WIDTH 8.
- `mode` port is typed `pr_mode_e`.
- One sub-module: `sat_counter` (parameter W; inputs clk, rst, clr, inc; output cnt). It is reusable by the weighting logic.
- Next-state selection is a single combinational case on mode.

## Test plan
- Reset mid-operation: LFSR running, rst pulled low between edges -> q = 0, count = 0, zero = 1 immediately, without waiting for an edge.
- set = 1 then LFSR en = 1 for 4 cycles, defaults -> q sequence 01, 02, 04, 08, 11; count = 4.
- LOAD d = 8'hA5, then SHIFT si = 1 then si = 0 -> q = A5, 4B, 96. so = 1, 0, 1 after each edge.
- ROTATE from 8'h81 for 2 cycles -> 03, 06.
- Lock-up: from reset (q = 0), mode LFSR, en = 1 -> q = 01, count = 1. Same cycle with set = 1 -> q = 01, count = 0.
- Saturation with CNT_W = 3: 9 enabled edges -> count 1..7 then stays 7. en = 0 -> q and count hold for 3 cycles.
